// File: rtl/pixel_swizzle_pkg.sv
// Shared types and constants for the pixel_swizzle video stage.
// Mode encoding, luma weights and the identity permutation builder.
package pixel_swizzle_pkg;

  typedef enum logic [1:0] {
    PXM_BYPASS  = 2'b00,
    PXM_PERMUTE = 2'b01,
    PXM_INVERT  = 2'b10,
    PXM_GRAY    = 2'b11
  } pxm_e;

  localparam int LUMA_C0    = 77;
  localparam int LUMA_C1    = 150;
  localparam int LUMA_C2    = 29;
  localparam int LUMA_RND   = 128;
  localparam int LUMA_SHIFT = 8;

  // Field i of the result holds the value i, fields SELW bits wide.
  function automatic logic [31:0] ident_perm(
    input int nch,
    input int selw
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nch; i++) begin
      r = r | (32'(i) << (i * selw));
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_swizzle_if.sv
// Pixel stream bundle: data with sof/eol side bits and valid/ready.
// The master drives the beat, the slave drives ready.
interface pixel_swizzle_if #(
  parameter int W = 24
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         sof;
  logic         eol;

  modport master (
    output data, valid, sof, eol,
    input  ready
  );

  modport slave (
    input  data, valid, sof, eol,
    output ready
  );

endinterface

// File: rtl/pixel_swizzle_skid.sv
// pix_skid_buf: output register plus one-entry skid buffer.
// in_ready is a flop meaning "skid empty", so no comb path to out_ready.
module pix_skid_buf #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;

  // Fill the output register directly; park a beat in skid on a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b1;
    end else if (in_ready) begin
      if (!out_valid || out_ready) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
        end
      end else if (in_valid) begin
        skid_data <= in_data;
        in_ready  <= 1'b0;
      end
    end else if (out_ready) begin
      out_data  <= skid_data;
      out_valid <= 1'b1;
      in_ready  <= 1'b1;
    end
  end

endmodule

// File: rtl/pixel_swizzle.sv
// Per-pixel channel permute/invert stage, config shadowed at frame start.
// Optional luma mode (extra multiply stage) under PIXEL_SWIZZLE_GRAY_EN.
module pixel_swizzle
  import pixel_swizzle_pkg::*;
#(
  parameter  int CW   = 8,
  parameter  int NCH  = 3,
  parameter  int FCW  = 16,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cfg_mode,
  input  logic [NCH*SELW-1:0]  cfg_perm,
  pixel_swizzle_if.slave       s,
  pixel_swizzle_if.master      m,
  output logic                 cfg_err,
  output logic [FCW-1:0]       frame_cnt
);

  localparam int DW = NCH * CW;
  localparam logic [31:0] ID_ALL = ident_perm(NCH, SELW);
  localparam logic [NCH*SELW-1:0] ID_PERM = ID_ALL[NCH*SELW-1:0];

  pxm_e                sh_mode;
  pxm_e                mode;
  logic [NCH*SELW-1:0] sh_perm;
  logic [NCH*SELW-1:0] perm;
  logic                acc;
  logic                err_hit;
  logic                use_perm;
  logic [CW-1:0]       chn [NCH];
  logic [NCH-1:0]      bad;
  logic [DW-1:0]       pdata;
  logic [DW-1:0]       idata;
  logic [DW-1:0]       xdata;
  logic                in_rdy;
  logic [DW+1:0]       o_data;
  logic                o_valid;

  assign acc  = s.valid & in_rdy;
  assign mode = s.sof ? pxm_e'(cfg_mode) : sh_mode;
  assign perm = s.sof ? cfg_perm : sh_perm;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SELW-1:0] idx;
    assign idx    = perm[i*SELW +: SELW];
    assign bad[i] = int'(idx) >= NCH;
    assign chn[i] = bad[i] ? '0 : s.data[int'(idx)*CW +: CW];
    assign pdata[i*CW +: CW] = chn[i];
    assign idata[i*CW +: CW] = bad[i] ? '0 : ~chn[i];
  end

  // Select transformed pixel for the mode in force for this beat
  always_comb begin
    xdata    = s.data;
    use_perm = 1'b0;
    unique case (1'b1)
      (mode == PXM_PERMUTE): begin
        xdata    = pdata;
        use_perm = 1'b1;
      end
      (mode == PXM_INVERT): begin
        xdata    = idata;
        use_perm = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIXEL_SWIZZLE_GRAY_EN
  localparam int PW = CW + 8;
  localparam int AW = 3 + DW + 3 * PW;

  if (NCH < 3) begin : g_nch_chk
    $error("pixel_swizzle: luma mode needs NCH >= 3");
  end

  logic          is_gray;
  logic [PW-1:0] p0, p1, p2;
  logic [AW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [PW-1:0] a_p0, a_p1, a_p2;
  logic [DW-1:0] a_x;
  logic          a_g, a_sof, a_eol;
  logic [PW-1:0] y_sum;
  logic [CW-1:0] y;

  assign is_gray = (mode == PXM_GRAY);
  assign err_hit = acc & ((use_perm & (|bad)) | (is_gray & (|bad[2:0])));

  assign p0 = PW'(LUMA_C0) * PW'(chn[0]);
  assign p1 = PW'(LUMA_C1) * PW'(chn[1]);
  assign p2 = PW'(LUMA_C2) * PW'(chn[2]);

  pix_skid_buf #(.WIDTH(AW)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s.sof, s.eol, is_gray, xdata, p0, p1, p2}),
    .in_valid  (s.valid),
    .in_ready  (in_rdy),
    .out_data  (a_data),
    .out_valid (a_valid),
    .out_ready (a_ready)
  );

  assign a_p2  = a_data[PW-1:0];
  assign a_p1  = a_data[2*PW-1:PW];
  assign a_p0  = a_data[3*PW-1:2*PW];
  assign a_x   = a_data[3*PW +: DW];
  assign a_g   = a_data[3*PW+DW];
  assign a_eol = a_data[3*PW+DW+1];
  assign a_sof = a_data[3*PW+DW+2];
  assign y_sum = a_p0 + a_p1 + a_p2 + PW'(LUMA_RND);
  assign y     = y_sum[PW-1:LUMA_SHIFT];

  pix_skid_buf #(.WIDTH(DW+2)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({a_sof, a_eol, a_g ? {NCH{y}} : a_x}),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .out_data  (o_data),
    .out_valid (o_valid),
    .out_ready (m.ready)
  );
`else
  assign err_hit = acc & use_perm & (|bad);

  pix_skid_buf #(.WIDTH(DW+2)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s.sof, s.eol, xdata}),
    .in_valid  (s.valid),
    .in_ready  (in_rdy),
    .out_data  (o_data),
    .out_valid (o_valid),
    .out_ready (m.ready)
  );
`endif

  assign s.ready = in_rdy;
  assign m.data  = o_data[DW-1:0];
  assign m.eol   = o_data[DW];
  assign m.sof   = o_data[DW+1];
  assign m.valid = o_valid;

  // Shadow config loads with each accepted sof beat; error is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mode <= PXM_BYPASS;
      sh_perm <= ID_PERM;
      cfg_err <= 1'b0;
    end else begin
      if (acc && s.sof) begin
        sh_mode <= pxm_e'(cfg_mode);
        sh_perm <= cfg_perm;
      end
      if (err_hit) begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Count frames as their first pixel leaves the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (o_valid && m.ready && o_data[DW+1]) begin
      frame_cnt <= frame_cnt + FCW'(1);
    end
  end

endmodule

// File: tb/tb_pixel_swizzle.sv
// Directed bench for pixel_swizzle (NCH=3, CW=8, FCW=4).
// Luma checks build only when PIXEL_SWIZZLE_GRAY_EN is defined.
module tb_pixel_swizzle;

  localparam int CW  = 8;
  localparam int NCH = 3;
  localparam int FCW = 4;
  localparam int DW  = 24;
`ifdef PIXEL_SWIZZLE_GRAY_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NBEAT = 1000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     cfg_mode;
  logic [5:0]     cfg_perm;
  logic           cfg_err;
  logic [FCW-1:0] frame_cnt;
  int             checks = 0;
  int             errors = 0;

  pixel_swizzle_if #(.W(DW)) s_if ();
  pixel_swizzle_if #(.W(DW)) m_if ();

  pixel_swizzle #(.CW(CW), .NCH(NCH), .FCW(FCW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_mode  (cfg_mode),
    .cfg_perm  (cfg_perm),
    .s         (s_if),
    .m         (m_if),
    .cfg_err   (cfg_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pat(input int i);
    return 24'(i * 37 + 256);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s_if.valid = 1'b0;
    s_if.sof = 1'b0;
    s_if.eol = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] d, input logic sof, input logic eol);
    s_if.data = d;
    s_if.sof = sof;
    s_if.eol = eol;
    s_if.valid = 1'b1;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.sof = 1'b0;
    s_if.eol = 1'b0;
    repeat (LAT - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (m_if.valid !== 1'b0) begin
      errors++; $display("FAIL rst_m_valid got %0b exp 0", m_if.valid);
    end
    checks++;
    if (m_if.data !== 24'h0) begin
      errors++; $display("FAIL rst_m_data got %h exp 000000", m_if.data);
    end
    checks++;
    if (m_if.sof !== 1'b0 || m_if.eol !== 1'b0) begin
      errors++; $display("FAIL rst_sof_eol got %b%b exp 00", m_if.sof, m_if.eol);
    end
    checks++;
    if (s_if.ready !== 1'b1) begin
      errors++; $display("FAIL rst_s_ready got %0b exp 1", s_if.ready);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL rst_cfg_err got %0b exp 0", cfg_err);
    end
    checks++;
    if (frame_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt);
    end
  endtask

  task automatic test_permute();
    int lat;
    cfg_mode = 2'b01;
    cfg_perm = 6'b10_00_01;
    m_if.ready = 1'b1;
    s_if.data = 24'hAABBCC;
    s_if.sof = 1'b1;
    s_if.eol = 1'b0;
    s_if.valid = 1'b1;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.sof = 1'b0;
    lat = 1;
    while (m_if.valid !== 1'b1 && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != LAT) begin
      errors++; $display("FAIL perm_latency got %0d exp %0d", lat, LAT);
    end
    checks++;
    if (m_if.data !== 24'hAACCBB) begin
      errors++; $display("FAIL perm_data got %h exp aaccbb", m_if.data);
    end
    checks++;
    if (m_if.sof !== 1'b1) begin
      errors++; $display("FAIL perm_sof got %0b exp 1", m_if.sof);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_if.valid !== 1'b0) begin
      errors++; $display("FAIL perm_no_dup got %0b exp 0", m_if.valid);
    end
  endtask

  task automatic test_invert_shadow();
    cfg_mode = 2'b10;
    cfg_perm = 6'b10_01_00;
    push(24'h123456, 1'b1, 1'b0);
    checks++;
    if (m_if.data !== 24'hEDCBA9) begin
      errors++; $display("FAIL inv_data got %h exp edcba9", m_if.data);
    end
    cfg_mode = 2'b00;
    push(24'h123456, 1'b0, 1'b0);
    checks++;
    if (m_if.data !== 24'hEDCBA9 || m_if.sof !== 1'b0) begin
      errors++; $display("FAIL inv_midframe got %h sof %0b exp edcba9 sof 0", m_if.data, m_if.sof);
    end
    push(24'h123456, 1'b1, 1'b1);
    checks++;
    if (m_if.data !== 24'h123456 || m_if.eol !== 1'b1) begin
      errors++; $display("FAIL inv_newframe got %h eol %0b exp 123456 eol 1", m_if.data, m_if.eol);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int sent;
    int rcvd;
    int cyc;
    logic held;
    logic ofire;
    logic ifire;
    logic [23:0] hd;
    sent = 0;
    rcvd = 0;
    cyc = 0;
    held = 1'b0;
    hd = '0;
    cfg_mode = 2'b00;
    m_if.ready = 1'($urandom % 2);
    s_if.valid = 1'b1;
    s_if.data = pat(0);
    s_if.sof = 1'b1;
    s_if.eol = 1'b0;
    while (rcvd < NBEAT && cyc < 20000) begin
      @(negedge clk);
      if (m_if.valid === 1'b1) begin
        if (held) begin
          checks++;
          if (m_if.data !== hd) begin
            errors++; $display("FAIL stall_stable got %h exp %h", m_if.data, hd);
          end
        end
        checks++;
        if (m_if.data !== pat(rcvd) || m_if.sof !== (rcvd == 0)) begin
          errors++;
          $display("FAIL stream_beat%0d got %h sof %0b exp %h", rcvd, m_if.data, m_if.sof, pat(rcvd));
        end
      end else if (held) begin
        checks++;
        errors++;
        $display("FAIL stall_valid got 0 exp 1");
      end
      ofire = m_if.valid & m_if.ready;
      ifire = s_if.valid & s_if.ready;
      held = m_if.valid & ~m_if.ready;
      hd = m_if.data;
      @(posedge clk);
      #1;
      cyc++;
      if (ofire) rcvd++;
      if (ifire) sent++;
      s_if.valid = (sent < NBEAT);
      s_if.data = pat(sent);
      s_if.sof = (sent == 0);
      s_if.eol = (sent % 16 == 15);
      m_if.ready = 1'($urandom % 2);
    end
    s_if.valid = 1'b0;
    s_if.sof = 1'b0;
    s_if.eol = 1'b0;
    m_if.ready = 1'b1;
    checks++;
    if (rcvd != NBEAT || sent != NBEAT) begin
      errors++; $display("FAIL stream_count got %0d/%0d exp %0d", rcvd, sent, NBEAT);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_if.valid !== 1'b0) begin
      errors++; $display("FAIL stream_extra got %0b exp 0", m_if.valid);
    end
  endtask

  task automatic test_cfg_err();
    cfg_mode = 2'b01;
    cfg_perm = 6'b10_01_11;
    m_if.ready = 1'b1;
    push(24'hAABBCC, 1'b1, 1'b0);
    checks++;
    if (m_if.data !== 24'hAABB00) begin
      errors++; $display("FAIL err_data got %h exp aabb00", m_if.data);
    end
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL err_set got %0b exp 1", cfg_err);
    end
    cfg_perm = 6'b10_01_00;
    push(24'hAABBCC, 1'b1, 1'b0);
    checks++;
    if (m_if.data !== 24'hAABBCC) begin
      errors++; $display("FAIL err_reload_data got %h exp aabbcc", m_if.data);
    end
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %0b exp 1", cfg_err);
    end
    do_reset();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %0b exp 0", cfg_err);
    end
  endtask

  task automatic test_frames_reset();
    do_reset();
    cfg_mode = 2'b00;
    m_if.ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(24'(i), 1'b1, 1'b1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (frame_cnt !== 4'd1) begin
      errors++; $display("FAIL frame_wrap got %0d exp 1", frame_cnt);
    end
    cfg_mode = 2'b01;
    cfg_perm = 6'b10_00_01;
    m_if.ready = 1'b0;
    push(24'hAABBCC, 1'b1, 1'b0);
    push(24'h111111, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_if.valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got %0b exp 0", m_if.valid);
    end
    checks++;
    if (frame_cnt !== 4'd0) begin
      errors++; $display("FAIL midrst_frame_cnt got %0d exp 0", frame_cnt);
    end
    rst_n = 1'b1;
    m_if.ready = 1'b1;
    @(posedge clk);
    #1;
    push(24'hAABBCC, 1'b0, 1'b0);
    checks++;
    if (m_if.valid !== 1'b1 || m_if.data !== 24'hAABBCC) begin
      errors++; $display("FAIL midrst_bypass got %h v%0b exp aabbcc", m_if.data, m_if.valid);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef PIXEL_SWIZZLE_GRAY_EN
  task automatic test_gray();
    cfg_mode = 2'b11;
    cfg_perm = 6'b10_01_00;
    m_if.ready = 1'b1;
    push(24'hFFFFFF, 1'b1, 1'b0);
    checks++;
    if (m_if.data !== 24'hFFFFFF) begin
      errors++; $display("FAIL gray_white got %h exp ffffff", m_if.data);
    end
    push(24'h0000FF, 1'b0, 1'b0);
    checks++;
    if (m_if.data !== 24'h4D4D4D) begin
      errors++; $display("FAIL gray_c0 got %h exp 4d4d4d", m_if.data);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    cfg_mode = 2'b00;
    cfg_perm = 6'b10_01_00;
    s_if.data = '0;
    s_if.valid = 1'b0;
    s_if.sof = 1'b0;
    s_if.eol = 1'b0;
    m_if.ready = 1'b1;
    #1;
    test_reset();
    test_permute();
    test_invert_shadow();
    test_back_to_back();
    test_cfg_err();
    test_frames_reset();
`ifdef PIXEL_SWIZZLE_GRAY_EN
    test_gray();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
